// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: operands are split into STAGES chunks and one chunk is
// added per stage, with the inter-chunk carry registered. Valid/ready on both sides;
// a stalled output freezes the whole pipeline.
module pipelined_addsub #(
    parameter int unsigned NUMBITS = 16,
    parameter int unsigned STAGES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               carryin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero
);

    localparam int unsigned CHUNK = NUMBITS / STAGES;

    // Stage registers: stage k holds the operands, the result chunks 0..k and the
    // carry out of chunk k for the beat it currently owns.
    logic [STAGES-1:0]              r_vld;
    logic [STAGES-1:0][NUMBITS-1:0] r_a;
    logic [STAGES-1:0][NUMBITS-1:0] r_b;
    logic [STAGES-1:0][NUMBITS-1:0] r_res;
    logic [STAGES-1:0]              r_c;
    logic                           r_ovf;
    logic                           r_zero;

    // Per-stage inputs (from the port for stage 0, from the previous stage otherwise)
    logic [STAGES-1:0]              w_v_in;
    logic [STAGES-1:0]              w_c_in;
    logic [STAGES-1:0]              w_cout;
    logic [STAGES-1:0][NUMBITS-1:0] w_a_in;
    logic [STAGES-1:0][NUMBITS-1:0] w_b_in;
    logic [STAGES-1:0][NUMBITS-1:0] w_res_in;
    logic [STAGES-1:0][NUMBITS-1:0] w_res_nx;
    logic [STAGES-1:0][CHUNK-1:0]   w_sum;
    logic                           w_stall;
    logic                           w_ovf_nx;
    logic                           w_zero_nx;
    logic                           w_unused_ops;

    assign w_stall = r_vld[STAGES-1] & ~out_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                // B is inverted once on entry; subtract also forces the initial carry to 1
                assign w_v_in[k]   = in_valid;
                assign w_a_in[k]   = A;
                assign w_b_in[k]   = sub ? ~B : B;
                assign w_c_in[k]   = sub | carryin;
                assign w_res_in[k] = '0;
            end else begin : g_next
                assign w_v_in[k]   = r_vld[k-1];
                assign w_a_in[k]   = r_a[k-1];
                assign w_b_in[k]   = r_b[k-1];
                assign w_c_in[k]   = r_c[k-1];
                assign w_res_in[k] = r_res[k-1];
            end

            assign {w_cout[k], w_sum[k]} = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                                         + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                                         + {{CHUNK{1'b0}}, w_c_in[k]};

            // Chunk k of the incoming partial result is still zero, so OR inserts it
            assign w_res_nx[k] = w_res_in[k] | (NUMBITS'(w_sum[k]) << (k * CHUNK));
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits
    assign w_ovf_nx  = w_cout[STAGES-1]
                     ^ (w_a_in[STAGES-1][NUMBITS-1] ^ w_b_in[STAGES-1][NUMBITS-1]
                        ^ w_sum[STAGES-1][CHUNK-1]);
    assign w_zero_nx = (w_res_nx[STAGES-1] == '0);

    // The last stage never forwards its operand copies
    assign w_unused_ops = ^{r_a[STAGES-1], r_b[STAGES-1]};

    // Advance every stage together unless the output is stalled; bubbles leave data alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_c    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            r_vld <= w_v_in;
            for (int i = 0; i < int'(STAGES); i++) begin
                if (w_v_in[i]) begin
                    r_a[i]   <= w_a_in[i];
                    r_b[i]   <= w_b_in[i];
                    r_res[i] <= w_res_nx[i];
                    r_c[i]   <= w_cout[i];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_ovf  <= w_ovf_nx;
                r_zero <= w_zero_nx;
            end
        end
    end

    assign in_ready  = ~w_stall;
    assign out_valid = r_vld[STAGES-1];
    assign result    = r_res[STAGES-1];
    assign carryout  = r_c[STAGES-1];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four instances (STAGES = 1, 2, 4, 16) share one stimulus
// stream; each keeps its own expected-result FIFO filled from an arithmetic model.
module tb_pipelined_addsub;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        carryin   = 1'b0;
    logic        sub       = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] A         = '0;
    logic [15:0] B         = '0;

    logic [3:0]       in_ready_w;
    logic [3:0]       out_valid_w;
    logic [3:0]       co_w;
    logic [3:0]       ov_w;
    logic [3:0]       z_w;
    logic [3:0][15:0] res_w;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pops4   = 0;
    bit chk_lat = 1'b0;

    typedef struct packed {
        logic [18:0] want;
        logic [31:0] acc;
    } ent_t;

    ent_t sb_mem [4][64];
    int   wr_p   [4];
    int   rd_p   [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            pipelined_addsub #(
                .NUMBITS(16),
                .STAGES (1 << (g == 3 ? 4 : g))
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid),
                .in_ready (in_ready_w[g]),
                .A        (A),
                .B        (B),
                .carryin  (carryin),
                .sub      (sub),
                .out_valid(out_valid_w[g]),
                .out_ready(out_ready),
                .result   (res_w[g]),
                .carryout (co_w[g]),
                .overflow (ov_w[g]),
                .zero     (z_w[g])
            );
        end
    endgenerate

    function automatic int stages_of(input int d);
        return (d == 3) ? 16 : (1 << d);
    endfunction

    // Reference: whole-word arithmetic, signed overflow from operand/result sign bits
    function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic ci, input logic sb);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] r;
        bb   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 17'(sb ? 1'b1 : ci);
        r    = full[15:0];
        return {r, full[16], (a[15] == bb[15]) && (r[15] != a[15]), r == 16'h0};
    endfunction

    function automatic logic [18:0] obs(input int d);
        return {res_w[d], co_w[d], ov_w[d], z_w[d]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: drive at negedge, then score the handshakes the next posedge will see
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input logic ordy);
        ent_t e;
        @(negedge clk);
        in_valid  = iv;
        A         = a;
        B         = b;
        carryin   = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        for (int d = 0; d < 4; d++) begin
            if (out_valid_w[d] && out_ready) begin
                check($sformatf("pending_d%0d", d), 64'(wr_p[d] > rd_p[d]), 64'd1);
                if (wr_p[d] > rd_p[d]) begin
                    e = sb_mem[d][rd_p[d] % 64];
                    rd_p[d]++;
                    check($sformatf("fields_d%0d", d), 64'(obs(d)), 64'(e.want));
                    if (chk_lat)
                        check($sformatf("latency_d%0d", d), 64'(cyc - int'(e.acc)),
                              64'(stages_of(d)));
                    if (d == 2) pops4++;
                end
            end
            if (in_valid && in_ready_w[d]) begin
                e.want = ref_model(A, B, carryin, sub);
                e.acc  = 32'(cyc);
                sb_mem[d][wr_p[d] % 64] = e;
                wr_p[d]++;
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    // One-cycle reset pulse; in-flight beats are forgotten by the scoreboard too
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            wr_p[d] = 0;
            rd_p[d] = 0;
        end
        #1;
        for (int d = 0; d < 4; d++)
            check($sformatf("reset_d%0d", d), 64'({in_ready_w[d], out_valid_w[d], obs(d)}),
                  64'({1'b1, 20'h0}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Plain add, exact latency on the 4-stage instance
        chk_lat = 1'b1;
        cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        repeat (3) idle();
        check("t1_not_early", 64'(out_valid_w[2]), 64'd0);
        idle();
        check("t1_valid", 64'(out_valid_w[2]), 64'd1);
        check("t1_fields", 64'(obs(2)), 64'({16'h2345, 3'b000}));

        // Carry rippling through every chunk
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        repeat (4) idle();
        check("t2_valid", 64'(out_valid_w[2]), 64'd1);
        check("t2_fields", 64'(obs(2)), 64'({16'h0000, 3'b101}));

        // Subtract: signed overflow, then borrow; carryin=1 must be ignored
        cycle(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
        repeat (3) idle();
        check("t3a_fields", 64'({out_valid_w[2], obs(2)}), 64'({1'b1, 16'h7FFF, 3'b110}));
        idle();
        check("t3b_fields", 64'({out_valid_w[2], obs(2)}), 64'({1'b1, 16'hFFFE, 3'b000}));

        // Eight back-to-back beats: exact latency each means eight consecutive results
        pops4 = 0;
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        repeat (4) idle();
        check("t4_count", 64'(pops4), 64'd8);

        // Three-cycle output stall mid-stream
        chk_lat = 1'b0;
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            check($sformatf("t4_stall_ready_%0d", i), 64'(in_ready_w[2]), 64'd0);
            check($sformatf("t4_stall_hold_%0d", i), 64'({out_valid_w[2], obs(2)}),
                  64'({1'b1, sb_mem[2][rd_p[2] % 64].want}));
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        repeat (20) idle();
        check("t4_no_loss", 64'(wr_p[2] - rd_p[2]), 64'd0);

        // Reset with beats in flight, then a fresh beat sees full latency
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            for (int d = 0; d < 4; d++)
                check($sformatf("t5_quiet_%0d_d%0d", i, d), 64'({out_valid_w[d], obs(d)}),
                      64'd0);
        end
        cycle(1'b1, 16'h00FF, 16'h0F0F, 1'b1, 1'b0, 1'b1);
        repeat (3) idle();
        check("t5_not_early", 64'(out_valid_w[2]), 64'd0);
        idle();
        check("t5_valid", 64'(out_valid_w[2]), 64'd1);

        // Random traffic with random backpressure on all four depths
        do_reset();
        chk_lat = 1'b0;
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 9) < 7);
        repeat (40) idle();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("drain_d%0d", d), 64'(wr_p[d] - rd_p[d]), 64'd0);
            check($sformatf("drain_valid_d%0d", d), 64'(out_valid_w[d]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
